// File: rtl/game_state_ctrl_if.sv
// -----------------------------------------------------------------------------
// game_state_ctrl_if
// Groups the frame tick, controller buttons, collision flags and the game state
// outputs exchanged between the Pong state controller and its neighbours.
//   master : drives the inputs (frame tick, buttons, collisions), reads state
//   slave  : the game_state_ctrl itself
// Signals:
//   vSyncStart               one-cycle frame tick
//   buttons[7:0]             debounced controller buttons, 1 = pressed
//   collisionBallScreenLeft  ball reached left edge (computer point)
//   collisionBallScreenRight ball reached right edge (player point)
//   state[7:0]               0 GameOver, 1 Playing, 2 PlayerScored,
//                            3 ComputerScored, 4 Paused
//   playerScore/computerScore score counters
//   winner[1:0]              0 none, 1 player, 2 computer
//   serveToPlayer            next serve travels toward the player
//   delayActive              scored-state frame delay running
// -----------------------------------------------------------------------------
interface game_state_ctrl_if #(
    parameter int SCORE_W = 4
);
    logic               vSyncStart;
    logic [7:0]         buttons;
    logic               collisionBallScreenLeft;
    logic               collisionBallScreenRight;
    logic [7:0]         state;
    logic [SCORE_W-1:0] playerScore;
    logic [SCORE_W-1:0] computerScore;
    logic [1:0]         winner;
    logic               serveToPlayer;
    logic               delayActive;

    modport master (
        output vSyncStart,
        output buttons,
        output collisionBallScreenLeft,
        output collisionBallScreenRight,
        input  state,
        input  playerScore,
        input  computerScore,
        input  winner,
        input  serveToPlayer,
        input  delayActive
    );

    modport slave (
        input  vSyncStart,
        input  buttons,
        input  collisionBallScreenLeft,
        input  collisionBallScreenRight,
        output state,
        output playerScore,
        output computerScore,
        output winner,
        output serveToPlayer,
        output delayActive
    );
endinterface

// File: rtl/game_state_ctrl.sv
// -----------------------------------------------------------------------------
// game_state_ctrl
// Frame-rate Pong game state controller. Tracks both scores, sequences the
// game through GameOver / Playing / PlayerScored / ComputerScored / Paused,
// handles pause, serve side, a win score with a minimum winning lead, and a
// scored-state delay before a serve is accepted. Every register advances only
// on pixelClock edges where vSyncStart is high; all outputs are registered.
// Ports:
//   pixelClock  system clock
//   resetN      asynchronous active-low reset
//   bus         game_state_ctrl_if.slave (frame tick, buttons, collisions in;
//               state, scores, winner, serveToPlayer, delayActive out)
// -----------------------------------------------------------------------------
module game_state_ctrl #(
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int WIN_MARGIN   = 1,
    parameter int DELAY_FRAMES = 120,
    parameter int START_BTN    = 3,
    parameter int SERVE_BTN    = 7
) (
    input  logic              pixelClock,
    input  logic              resetN,
    game_state_ctrl_if.slave  bus
);

    // A zero-frame delay still needs a one-bit counter to hold the value 0.
    localparam int CNT_W = (DELAY_FRAMES > 0) ? $clog2(DELAY_FRAMES + 1) : 1;
    // Margin arithmetic is done wider than the scores so sums never wrap.
    localparam int MW    = SCORE_W + 2;

    localparam logic [CNT_W-1:0]   DELAY_C      = CNT_W'(DELAY_FRAMES);
    localparam logic [CNT_W-1:0]   CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_ZERO   = {SCORE_W{1'b0}};
    localparam logic [SCORE_W-1:0] SCORE_MAX    = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_ONE    = SCORE_W'(1);
    localparam logic [MW-1:0]      WIN_SCORE_C  = MW'(WIN_SCORE);
    localparam logic [MW-1:0]      WIN_MARGIN_C = MW'(WIN_MARGIN);

    typedef enum logic [2:0] {
        ST_OVER     = 3'd0,
        ST_PLAYING  = 3'd1,
        ST_PSCORED  = 3'd2,
        ST_CSCORED  = 3'd3,
        ST_PAUSED   = 3'd4
    } state_t;

    // Saturating score increment.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] res;
        if (v == SCORE_MAX) begin
            res = SCORE_MAX;
        end else begin
            res = v + SCORE_ONE;
        end
        return res;
    endfunction

    // True when scorer s has reached the win score with the required lead over o.
    function automatic logic win_reached(input logic [SCORE_W-1:0] s,
                                         input logic [SCORE_W-1:0] o);
        logic [MW-1:0] s_x;
        logic [MW-1:0] o_x;
        s_x = MW'(s);
        o_x = MW'(o);
        return (s_x >= WIN_SCORE_C) && (s_x >= (o_x + WIN_MARGIN_C));
    endfunction

    // Registered state
    state_t             state_r;
    logic [SCORE_W-1:0] player_score_r;
    logic [SCORE_W-1:0] computer_score_r;
    logic [1:0]         winner_r;
    logic               serve_to_player_r;
    logic               delay_active_r;
    logic [CNT_W-1:0]   count_r;
    logic               start_prev_r;
    logic               serve_armed_r;

    // Next-state values
    state_t             state_s;
    logic [SCORE_W-1:0] player_score_s;
    logic [SCORE_W-1:0] computer_score_s;
    logic [1:0]         winner_s;
    logic               serve_to_player_s;
    logic               delay_active_s;
    logic [CNT_W-1:0]   count_s;
    logic               start_prev_s;
    logic               serve_armed_s;

    // Helpers
    logic               start_press_s;
    logic               serve_btn_s;
    logic [SCORE_W-1:0] scorer_s;
    logic [SCORE_W-1:0] opponent_s;
    logic               win_s;

    assign start_press_s = bus.buttons[START_BTN] & ~start_prev_r;
    assign serve_btn_s   = bus.buttons[SERVE_BTN];

    // Select the scorer/opponent pair for the current scored state and evaluate the win rule.
    always_comb begin
        scorer_s   = player_score_r;
        opponent_s = computer_score_r;
        if (state_r == ST_CSCORED) begin
            scorer_s   = computer_score_r;
            opponent_s = player_score_r;
        end else begin
            scorer_s   = player_score_r;
            opponent_s = computer_score_r;
        end
        win_s = win_reached(scorer_s, opponent_s);
    end

    // Next-state and next-output logic; everything holds unless a frame tick is present.
    always_comb begin
        state_s           = state_r;
        player_score_s    = player_score_r;
        computer_score_s  = computer_score_r;
        winner_s          = winner_r;
        serve_to_player_s = serve_to_player_r;
        delay_active_s    = delay_active_r;
        count_s           = count_r;
        start_prev_s      = start_prev_r;
        serve_armed_s     = serve_armed_r;

        if (bus.vSyncStart) begin
            start_prev_s = bus.buttons[START_BTN];
            case (state_r)
                ST_OVER: begin
                    if (start_press_s) begin
                        state_s           = ST_PLAYING;
                        player_score_s    = SCORE_ZERO;
                        computer_score_s  = SCORE_ZERO;
                        winner_s          = 2'd0;
                        serve_to_player_s = 1'b1;
                        serve_armed_s     = 1'b0;
                        delay_active_s    = 1'b0;
                    end else begin
                        state_s = ST_OVER;
                    end
                end

                ST_PLAYING: begin
                    // Start beats collisions; right beats left when both hit together.
                    if (start_press_s) begin
                        state_s = ST_PAUSED;
                    end else if (bus.collisionBallScreenRight) begin
                        state_s           = ST_PSCORED;
                        player_score_s    = sat_inc(player_score_r);
                        serve_to_player_s = 1'b0;
                        count_s           = CNT_ZERO;
                        serve_armed_s     = 1'b0;
                    end else if (bus.collisionBallScreenLeft) begin
                        state_s           = ST_CSCORED;
                        computer_score_s  = sat_inc(computer_score_r);
                        serve_to_player_s = 1'b1;
                        count_s           = CNT_ZERO;
                        serve_armed_s     = 1'b0;
                    end else begin
                        state_s = ST_PLAYING;
                    end
                end

                ST_PAUSED: begin
                    if (start_press_s) begin
                        state_s = ST_PLAYING;
                    end else begin
                        state_s = ST_PAUSED;
                    end
                end

                ST_PSCORED, ST_CSCORED: begin
                    // Win is only evaluated on the first frame in the state, before
                    // the delay counter has moved off zero.
                    if ((count_r == CNT_ZERO) && win_s) begin
                        state_s        = ST_OVER;
                        winner_s       = (state_r == ST_PSCORED) ? 2'd1 : 2'd2;
                        delay_active_s = 1'b0;
                    end else if (count_r != DELAY_C) begin
                        count_s        = count_r + CNT_ONE;
                        delay_active_s = 1'b1;
                    end else begin
                        delay_active_s = 1'b0;
                        // A must be seen released after the delay before a press serves,
                        // so a button held across the point never auto-serves.
                        if (serve_btn_s && serve_armed_r) begin
                            state_s       = ST_PLAYING;
                            serve_armed_s = 1'b0;
                        end else if (!serve_btn_s) begin
                            serve_armed_s = 1'b1;
                        end else begin
                            serve_armed_s = serve_armed_r;
                        end
                    end
                end

                default: begin
                    state_s = ST_OVER;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            state_r           <= ST_OVER;
            player_score_r    <= SCORE_ZERO;
            computer_score_r  <= SCORE_ZERO;
            winner_r          <= 2'd0;
            serve_to_player_r <= 1'b1;
            delay_active_r    <= 1'b0;
            count_r           <= CNT_ZERO;
            start_prev_r      <= 1'b1;
            serve_armed_r     <= 1'b0;
        end else begin
            state_r           <= state_s;
            player_score_r    <= player_score_s;
            computer_score_r  <= computer_score_s;
            winner_r          <= winner_s;
            serve_to_player_r <= serve_to_player_s;
            delay_active_r    <= delay_active_s;
            count_r           <= count_s;
            start_prev_r      <= start_prev_s;
            serve_armed_r     <= serve_armed_s;
        end
    end

    assign bus.state         = {5'b00000, state_r};
    assign bus.playerScore   = player_score_r;
    assign bus.computerScore = computer_score_r;
    assign bus.winner        = winner_r;
    assign bus.serveToPlayer = serve_to_player_r;
    assign bus.delayActive   = delay_active_r;

endmodule

// File: tb/tb_game_state_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_state_ctrl
// Self-checking bench for game_state_ctrl: table-driven vectors, hand-written
// multi-frame sequences (serve delay, win by margin, async reset mid-delay)
// and randomized frames checked against a behavioural game model.
// -----------------------------------------------------------------------------
module tb_game_state_ctrl;

    localparam int SW     = 4;
    localparam int WIN    = 9;
    localparam int MARGIN = 2;
    localparam int DELAY  = 120;
    localparam int START  = 3;
    localparam int SERVE  = 7;
    localparam int SMAX   = (1 << SW) - 1;

    logic clk;
    logic rst_n;

    game_state_ctrl_if #(.SCORE_W(SW)) bus ();

    game_state_ctrl #(
        .SCORE_W      (SW),
        .WIN_SCORE    (WIN),
        .WIN_MARGIN   (MARGIN),
        .DELAY_FRAMES (DELAY),
        .START_BTN    (START),
        .SERVE_BTN    (SERVE)
    ) dut (
        .pixelClock (clk),
        .resetN     (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode 0 over, 1 playing, 2 player scored,
    // 3 computer scored, 4 paused; m_f = frames already spent in a scored state.
    int m_mode, m_ps, m_cs, m_win, m_serve, m_delay, m_f;
    bit m_armed, m_prev;

    typedef struct {
        logic [7:0] btn;
        logic       l;
        logic       r;
        int         st;
        int         ps;
        int         cs;
        int         wn;
        int         sv;
        int         dl;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_ps = 0; m_cs = 0; m_win = 0; m_serve = 1;
        m_delay = 0; m_f = 0; m_armed = 1'b0; m_prev = 1'b1;
    endtask

    task automatic model_step(input logic [7:0] b, input logic l, input logic r);
        bit sp;
        int s, o;
        sp = b[START] && !m_prev;
        m_prev = b[START];
        if (m_mode == 0) begin
            if (sp) begin
                m_mode = 1; m_ps = 0; m_cs = 0; m_win = 0; m_serve = 1;
            end
        end else if (m_mode == 1) begin
            if (sp) m_mode = 4;
            else if (r) begin
                if (m_ps < SMAX) m_ps++;
                m_serve = 0; m_f = 0; m_armed = 1'b0; m_mode = 2;
            end else if (l) begin
                if (m_cs < SMAX) m_cs++;
                m_serve = 1; m_f = 0; m_armed = 1'b0; m_mode = 3;
            end
        end else if (m_mode == 4) begin
            if (sp) m_mode = 1;
        end else begin
            s = (m_mode == 2) ? m_ps : m_cs;
            o = (m_mode == 2) ? m_cs : m_ps;
            if (m_f == 0 && s >= WIN && (s - o) >= MARGIN) begin
                m_win = (m_mode == 2) ? 1 : 2;
                m_mode = 0;
                m_delay = 0;
            end else begin
                if (m_f < DELAY) m_delay = 1;
                else begin
                    m_delay = 0;
                    if (b[SERVE] && m_armed) begin
                        m_mode = 1; m_armed = 1'b0;
                    end else if (!b[SERVE]) m_armed = 1'b1;
                end
                m_f++;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ":state"}, int'(bus.state), m_mode);
        chk({tag, ":pscore"}, int'(bus.playerScore), m_ps);
        chk({tag, ":cscore"}, int'(bus.computerScore), m_cs);
        chk({tag, ":winner"}, int'(bus.winner), m_win);
        chk({tag, ":serve"}, int'(bus.serveToPlayer), m_serve);
        chk({tag, ":delay"}, int'(bus.delayActive), m_delay);
    endtask

    // One frame: tick edge with the given inputs, then a non-tick edge with
    // noise that must be ignored; outputs compared at the following negedge.
    task automatic do_frame(input logic [7:0] b, input logic l, input logic r);
        bus.vSyncStart = 1'b1;
        bus.buttons = b;
        bus.collisionBallScreenLeft = l;
        bus.collisionBallScreenRight = r;
        @(posedge clk);
        model_step(b, l, r);
        @(negedge clk);
        bus.vSyncStart = 1'b0;
        bus.buttons = 8'($urandom);
        bus.collisionBallScreenLeft = 1'($urandom);
        bus.collisionBallScreenRight = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        check_model("model");
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            do_frame(vecs[i].btn, vecs[i].l, vecs[i].r);
            chk($sformatf("vec%0d:state", i), int'(bus.state), vecs[i].st);
            chk($sformatf("vec%0d:pscore", i), int'(bus.playerScore), vecs[i].ps);
            chk($sformatf("vec%0d:cscore", i), int'(bus.computerScore), vecs[i].cs);
            chk($sformatf("vec%0d:winner", i), int'(bus.winner), vecs[i].wn);
            chk($sformatf("vec%0d:serve", i), int'(bus.serveToPlayer), vecs[i].sv);
            chk($sformatf("vec%0d:delay", i), int'(bus.delayActive), vecs[i].dl);
        end
    endtask

    // Score one point, sit out the delay with A released, then serve.
    task automatic score_point(input logic right);
        do_frame(8'h00, !right, right);
        for (int i = 0; i <= DELAY; i++) do_frame(8'h00, 1'b0, 1'b0);
        do_frame(8'h80, 1'b0, 1'b0);
        chk("point_serve:state", int'(bus.state), 1);
    endtask

    initial begin
        int hi_cnt;
        logic [7:0] rb;

        //           btn    l     r     st ps cs wn sv dl
        vecs[0]  = '{8'h08, 1'b0, 1'b0, 0, 0, 0, 0, 1, 0};
        vecs[1]  = '{8'h08, 1'b0, 1'b0, 0, 0, 0, 0, 1, 0};
        vecs[2]  = '{8'h08, 1'b0, 1'b0, 0, 0, 0, 0, 1, 0};
        vecs[3]  = '{8'h00, 1'b0, 1'b0, 0, 0, 0, 0, 1, 0};
        vecs[4]  = '{8'h08, 1'b0, 1'b0, 1, 0, 0, 0, 1, 0};
        vecs[5]  = '{8'h00, 1'b1, 1'b1, 2, 1, 0, 0, 0, 0};
        vecs[6]  = '{8'h08, 1'b0, 1'b0, 4, 1, 0, 0, 0, 0};
        vecs[7]  = '{8'h00, 1'b1, 1'b1, 4, 1, 0, 0, 0, 0};
        vecs[8]  = '{8'h00, 1'b0, 1'b1, 4, 1, 0, 0, 0, 0};
        vecs[9]  = '{8'h08, 1'b1, 1'b0, 1, 1, 0, 0, 0, 0};
        vecs[10] = '{8'h00, 1'b0, 1'b0, 1, 1, 0, 0, 0, 0};

        // Reset with Start held.
        rst_n = 1'b0;
        bus.vSyncStart = 1'b1;
        bus.buttons = 8'h08;
        bus.collisionBallScreenLeft = 1'b0;
        bus.collisionBallScreenRight = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset:state", int'(bus.state), 0);
        chk("reset:pscore", int'(bus.playerScore), 0);
        chk("reset:serve", int'(bus.serveToPlayer), 1);
        chk("reset:delay", int'(bus.delayActive), 0);
        check_model("reset");
        rst_n = 1'b1;
        bus.vSyncStart = 1'b0;
        @(negedge clk);

        // Start held through reset, release, press; simultaneous collisions.
        run_vecs(0, 5);

        // PlayerScored with A held throughout: delay must run, no serve.
        hi_cnt = 0;
        for (int i = 0; i < DELAY + 5; i++) begin
            do_frame(8'h80, 1'b0, 1'b0);
            if (bus.delayActive === 1'b1) hi_cnt++;
        end
        chk("held_a:delay_frames", hi_cnt, DELAY);
        chk("held_a:state", int'(bus.state), 2);
        do_frame(8'h00, 1'b0, 1'b0);
        chk("release_a:state", int'(bus.state), 2);
        do_frame(8'h80, 1'b0, 1'b0);
        chk("repress_a:state", int'(bus.state), 1);

        // Pause, collisions while paused, resume.
        run_vecs(6, 10);

        // Bring scores to 8/8 (currently 1/0).
        for (int i = 0; i < 8; i++) score_point(1'b0);
        for (int i = 0; i < 7; i++) score_point(1'b1);
        chk("eight_all:pscore", int'(bus.playerScore), 8);
        chk("eight_all:cscore", int'(bus.computerScore), 8);

        // 9/8 with margin 2 is not a win.
        do_frame(8'h00, 1'b0, 1'b1);
        chk("nine_eight:pscore", int'(bus.playerScore), 9);
        do_frame(8'h00, 1'b0, 1'b0);
        chk("nine_eight:state", int'(bus.state), 2);
        chk("nine_eight:winner", int'(bus.winner), 0);
        chk("nine_eight:delay", int'(bus.delayActive), 1);
        for (int i = 0; i < DELAY; i++) do_frame(8'h00, 1'b0, 1'b0);
        do_frame(8'h80, 1'b0, 1'b0);
        chk("nine_eight_serve:state", int'(bus.state), 1);

        // 10/8 wins.
        do_frame(8'h00, 1'b0, 1'b1);
        chk("ten_eight:pscore", int'(bus.playerScore), 10);
        do_frame(8'h00, 1'b0, 1'b0);
        chk("ten_eight:state", int'(bus.state), 0);
        chk("ten_eight:winner", int'(bus.winner), 1);
        chk("ten_eight:delay", int'(bus.delayActive), 0);

        // Randomized frames against the model.
        for (int i = 0; i < 3000; i++) begin
            rb = 8'($urandom) & 8'h77;
            if ($urandom_range(0, 7) == 0) rb[START] = 1'b1;
            if ($urandom_range(0, 1) == 1) rb[SERVE] = 1'b1;
            do_frame(rb, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        // Async reset mid-delay at counter 50.
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        do_frame(8'h00, 1'b0, 1'b0);
        do_frame(8'h08, 1'b0, 1'b0);
        do_frame(8'h00, 1'b1, 1'b0);
        chk("middelay:entry_state", int'(bus.state), 3);
        for (int i = 0; i < 50; i++) do_frame(8'h00, 1'b0, 1'b0);
        chk("middelay:delay_before", int'(bus.delayActive), 1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("middelay:state", int'(bus.state), 0);
        chk("middelay:cscore", int'(bus.computerScore), 0);
        chk("middelay:delay", int'(bus.delayActive), 0);
        check_model("middelay");
        @(negedge clk);
        rst_n = 1'b1;
        do_frame(8'h00, 1'b0, 1'b0);
        do_frame(8'h08, 1'b0, 1'b0);
        chk("after_reset:state", int'(bus.state), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
